// File: rtl/fetch_queue_stage.sv
// rtl/fetch_queue_stage.sv - MIPS fetch stage with prefetch queue and registered F/D interface
module fetch_queue_stage #(
    parameter int               XLEN      = 32,
    parameter int               IQ_DEPTH  = 4,
    parameter logic [XLEN-1:0]  RESET_PC  = '0,
    parameter logic [XLEN-1:0]  NOP_INSTR = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        stallD,
    input  logic                        flush,
    input  logic                        isbranchtakenE,
    input  logic [XLEN-1:0]             branchtargetE,
    output logic [XLEN-1:0]             imem_addr,
    input  logic [XLEN-1:0]             imem_rdata,
    output logic [XLEN-1:0]             instrD,
    output logic [XLEN-1:0]             pcD,
    output logic [XLEN-1:0]             pcplus4D,
    output logic                        validD,
    output logic [$clog2(IQ_DEPTH):0]   iq_count
);

    localparam int PW = $clog2(IQ_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0]   PTR_ONE  = PW'(1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]   CNT_FULL = CW'(IQ_DEPTH);
    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);

    logic [XLEN-1:0] iq_pc_q    [IQ_DEPTH];
    logic [XLEN-1:0] iq_instr_q [IQ_DEPTH];

    logic [XLEN-1:0] pcf_q, pcf_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] instrD_q, instrD_d;
    logic [XLEN-1:0] pcD_q, pcD_d;
    logic [XLEN-1:0] pcplus4D_q, pcplus4D_d;
    logic            validD_q, validD_d;

    logic full;
    logic push;
    logic pop;

    // Fullness uses the registered count, so a same-cycle pop never frees room for the push.
    assign full = (count_q == CNT_FULL);
    assign push = !full && !isbranchtakenE;
    assign pop  = !isbranchtakenE && !flush && !stallD && (count_q != '0);

    always_comb begin
        pcf_d      = pcf_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        instrD_d   = instrD_q;
        pcD_d      = pcD_q;
        pcplus4D_d = pcplus4D_q;
        validD_d   = validD_q;

        if (isbranchtakenE) begin
            pcf_d      = branchtargetE;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            instrD_d   = NOP_INSTR;
            pcD_d      = '0;
            pcplus4D_d = '0;
            validD_d   = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
                pcf_d    = pcf_q + PC_STEP;
            end

            if (flush || (!stallD && count_q == '0)) begin
                instrD_d   = NOP_INSTR;
                pcD_d      = '0;
                pcplus4D_d = '0;
                validD_d   = 1'b0;
            end else if (pop) begin
                instrD_d   = iq_instr_q[rd_ptr_q];
                pcD_d      = iq_pc_q[rd_ptr_q];
                pcplus4D_d = iq_pc_q[rd_ptr_q] + PC_STEP;
                validD_d   = 1'b1;
                rd_ptr_d   = rd_ptr_q + PTR_ONE;
            end

            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcf_q      <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            instrD_q   <= NOP_INSTR;
            pcD_q      <= '0;
            pcplus4D_q <= '0;
            validD_q   <= 1'b0;
        end else begin
            pcf_q      <= pcf_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            instrD_q   <= instrD_d;
            pcD_q      <= pcD_d;
            pcplus4D_q <= pcplus4D_d;
            validD_q   <= validD_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            iq_pc_q[wr_ptr_q]    <= pcf_q;
            iq_instr_q[wr_ptr_q] <= imem_rdata;
        end
    end

    assign imem_addr = pcf_q;
    assign instrD    = instrD_q;
    assign pcD       = pcD_q;
    assign pcplus4D  = pcplus4D_q;
    assign validD    = validD_q;
    assign iq_count  = count_q;

endmodule

// File: tb/tb_fetch_queue_stage.sv
// tb/tb_fetch_queue_stage.sv - scoreboard bench for fetch_queue_stage against a queue-based model
module tb_fetch_queue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallD;
    logic        flush;
    logic        isbranchtakenE;
    logic [31:0] branchtargetE;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instrD;
    logic [31:0] pcD;
    logic [31:0] pcplus4D;
    logic        validD;
    logic [2:0]  iq_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    typedef struct {
        logic        v;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] addr;
        logic [2:0]  cnt;
    } exp_t;

    exp_t   exp_q[$];
    entry_t mq[$];
    logic [31:0] m_pcf;
    exp_t   m_fd;

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

    fetch_queue_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stallD         (stallD),
        .flush          (flush),
        .isbranchtakenE (isbranchtakenE),
        .branchtargetE  (branchtargetE),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .instrD         (instrD),
        .pcD            (pcD),
        .pcplus4D       (pcplus4D),
        .validD         (validD),
        .iq_count       (iq_count)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, want, $time);
        end
    endtask

    function automatic void bubble();
        m_fd.v     = 1'b0;
        m_fd.instr = 32'h0;
        m_fd.pc    = 32'h0;
        m_fd.pc4   = 32'h0;
    endfunction

    // One clock of stimulus; the model advances from the same inputs and queues what F/D must show.
    task automatic cyc(input logic r, input logic st, input logic fl, input logic br, input logic [31:0] tgt);
        entry_t e;
        bit     was_full;
        exp_t   x;
        @(negedge clk);
        rst = r; stallD = st; flush = fl; isbranchtakenE = br; branchtargetE = tgt;
        if (r) begin
            m_pcf = 32'h0;
            mq.delete();
            bubble();
        end else if (br) begin
            m_pcf = tgt;
            mq.delete();
            bubble();
        end else begin
            was_full = (mq.size() == 4);
            if (fl) begin
                bubble();
            end else if (!st) begin
                if (mq.size() > 0) begin
                    e          = mq.pop_front();
                    m_fd.v     = 1'b1;
                    m_fd.instr = e.instr;
                    m_fd.pc    = e.pc;
                    m_fd.pc4   = e.pc + 32'd4;
                end else begin
                    bubble();
                end
            end
            if (!was_full) begin
                e.pc    = m_pcf;
                e.instr = m_pcf ^ 32'hA5A5_0000;
                mq.push_back(e);
                m_pcf = m_pcf + 32'd4;
            end
        end
        x      = m_fd;
        x.addr = m_pcf;
        x.cnt  = 3'(mq.size());
        exp_q.push_back(x);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("validD",    {31'b0, validD},   {31'b0, e.v});
                chk("instrD",    instrD,            e.instr);
                chk("pcD",       pcD,               e.pc);
                chk("pcplus4D",  pcplus4D,          e.pc4);
                chk("imem_addr", imem_addr,         e.addr);
                chk("iq_count",  {29'b0, iq_count}, {29'b0, e.cnt});
            end
        end
    end

    initial begin : stimulus
        rst = 1'b1; stallD = 1'b0; flush = 1'b0; isbranchtakenE = 1'b0; branchtargetE = 32'h0;
        m_pcf = 32'h0;
        bubble();

        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        repeat (8) cyc(0, 0, 0, 0, 0);
        repeat (6) cyc(0, 1, 0, 0, 0);
        repeat (6) cyc(0, 0, 0, 0, 0);
        repeat (5) cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 1, 32'h0000_0100);
        repeat (5) cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        repeat (5) cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            repeat (3) cyc(0, 1, 0, 0, 0);
            repeat (3) cyc(0, 0, 0, 0, 0);
        end
        cyc(0, 0, 0, 1, 32'hFFFF_FFF8);
        repeat (5) cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 99) == 0),
                ($urandom_range(0, 99) < 45),
                ($urandom_range(0, 99) < 10),
                ($urandom_range(0, 99) < 6),
                ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + ($urandom & 32'hC) : $urandom);
        end
        repeat (10) cyc(0, 0, 0, 0, 0);

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
